// File: rtl/music_kbd_pkg.sv
// Shared definitions for the music keyboard PS/2 front end.
//  - Set-2 scan codes for the note, octave and control keys, plus the break prefix.
//  - cmd_kind encoding used on the command interface.
//  - scan_lookup(): maps a command kind/value to its scan code and a valid flag.
package music_kbd_pkg;

    // Note keys, A..G# (command values 1..12)
    localparam logic [7:0] K_A     = 8'h1C;
    localparam logic [7:0] K_AS    = 8'h15;
    localparam logic [7:0] K_B     = 8'h1B;
    localparam logic [7:0] K_C     = 8'h23;
    localparam logic [7:0] K_CS    = 8'h24;
    localparam logic [7:0] K_D     = 8'h2B;
    localparam logic [7:0] K_DS    = 8'h2D;
    localparam logic [7:0] K_E     = 8'h34;
    localparam logic [7:0] K_F     = 8'h33;
    localparam logic [7:0] K_FS    = 8'h35;
    localparam logic [7:0] K_G     = 8'h3B;
    localparam logic [7:0] K_GS    = 8'h3C;
    // Octave keys 1..4 (command values 0..3)
    localparam logic [7:0] K_1     = 8'h16;
    localparam logic [7:0] K_2     = 8'h1E;
    localparam logic [7:0] K_3     = 8'h26;
    localparam logic [7:0] K_4     = 8'h25;
    // Control keys: space loads, enter starts playback
    localparam logic [7:0] K_SPACE = 8'h29;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_BREAK = 8'hF0;

    localparam logic [1:0] KindNote     = 2'd0;
    localparam logic [1:0] KindOctave   = 2'd1;
    localparam logic [1:0] KindPlayback = 2'd2;
    localparam logic [1:0] KindLoad     = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
    } scan_t;

    function automatic scan_t scan_lookup(input logic [1:0] kind, input logic [3:0] value);
        scan_t r;
        r.valid = 1'b1;
        r.code  = 8'h00;
        case (kind)
            KindNote: begin
                case (value)
                    4'd1:    r.code = K_A;
                    4'd2:    r.code = K_AS;
                    4'd3:    r.code = K_B;
                    4'd4:    r.code = K_C;
                    4'd5:    r.code = K_CS;
                    4'd6:    r.code = K_D;
                    4'd7:    r.code = K_DS;
                    4'd8:    r.code = K_E;
                    4'd9:    r.code = K_F;
                    4'd10:   r.code = K_FS;
                    4'd11:   r.code = K_G;
                    4'd12:   r.code = K_GS;
                    default: r.valid = 1'b0;
                endcase
            end
            KindOctave: begin
                case (value[1:0])
                    2'd0:    r.code = K_1;
                    2'd1:    r.code = K_2;
                    2'd2:    r.code = K_3;
                    default: r.code = K_4;
                endcase
            end
            KindPlayback: r.code = K_ENTER;
            default:      r.code = K_SPACE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// One-byte PS/2 device-side serializer.
//  - start_i (while idle) launches an 11-bit frame of byte_i: start 0, d0..d7, odd parity, stop 1.
//  - Each bit: clock high for HALF_BIT cycles (data changes on its first cycle), then low.
//  - busy_o is high for the whole frame; done_o pulses on the last low cycle of the stop bit.
//  - ps2_clk_o / ps2_dat_o are registered and idle high.
module ps2_frame_tx #(
    parameter int unsigned HALF_BIT = 2500
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ps2_clk_o,
    output logic       ps2_dat_o
);

    localparam int unsigned CntW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] HalfPre  = CntW'(HALF_BIT - 2);

    logic            active_q;
    logic            low_q;
    logic [CntW-1:0] hcnt_q;
    logic [3:0]      bit_q;
    logic [10:0]     sh_q;
    logic            clk_q;
    logic            dat_q;
    logic            done_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q <= 1'b0;
            low_q    <= 1'b0;
            hcnt_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '1;
            clk_q    <= 1'b1;
            dat_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !active_q) begin
                active_q <= 1'b1;
                low_q    <= 1'b0;
                hcnt_q   <= '0;
                bit_q    <= '0;
                // XNOR reduction gives the odd-parity bit
                sh_q     <= {1'b1, ~^byte_i, byte_i, 1'b0};
                clk_q    <= 1'b1;
                dat_q    <= 1'b0;
            end else if (active_q) begin
                if (hcnt_q == HalfLast) begin
                    hcnt_q <= '0;
                    if (!low_q) begin
                        low_q <= 1'b1;
                        clk_q <= 1'b0;
                    end else if (bit_q == 4'd10) begin
                        active_q <= 1'b0;
                        low_q    <= 1'b0;
                        clk_q    <= 1'b1;
                        dat_q    <= 1'b1;
                    end else begin
                        low_q <= 1'b0;
                        clk_q <= 1'b1;
                        bit_q <= bit_q + 4'd1;
                        sh_q  <= {1'b1, sh_q[10:1]};
                        dat_q <= sh_q[1];
                    end
                end else begin
                    hcnt_q <= hcnt_q + CntW'(1);
                end
                // Registered one cycle early so the pulse lands on the last stop-bit low cycle
                if (low_q && (bit_q == 4'd10) && (hcnt_q == HalfPre)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o    = active_q;
    assign done_o    = done_q;
    assign ps2_clk_o = clk_q;
    assign ps2_dat_o = dat_q;

endmodule

// File: rtl/ps2_scancode_tx.sv
// PS/2 scan-code transmitter: turns note/octave/playback/load commands into Set-2 frames.
//  - cmd_valid_i/cmd_ready_o: command handshake; kind/value/release latched on acceptance.
//  - Press sends the make code; release sends F0, gap, code. Every byte is followed by
//    GAP_CYCLES idle cycles. Invalid NOTE values pulse cmd_err_o and emit nothing.
//  - ps2_clk_o/ps2_dat_o: device-side PS/2 lines; byte_done_o pulses at each stop bit end;
//    cur_byte_o shows the byte being (or last) sent.
//  - Optional macro PS2_AUTO_BREAK_EN: a press sends code, F0, code as one command and
//    release commands are silently dropped.
module ps2_scancode_tx
    import music_kbd_pkg::*;
#(
    parameter int unsigned HALF_BIT   = 2500,
    parameter int unsigned GAP_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_kind_i,
    input  logic [3:0] cmd_value_i,
    input  logic       cmd_release_i,
    output logic       ps2_clk_o,
    output logic       ps2_dat_o,
    output logic       byte_done_o,
    output logic [7:0] cur_byte_o,
    output logic       cmd_err_o
);

`ifdef PS2_AUTO_BREAK_EN
    localparam bit AutoBreak = 1'b1;
`else
    localparam bit AutoBreak = 1'b0;
`endif

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StPrefix, StGap1, StCode, StGap2, StErr} state_e;

    state_e          state_q;
    logic [7:0]      code_q;
    logic [7:0]      cur_byte_q;
    logic            err_q;
    logic [GapW-1:0] gap_q;
    logic            brk_pending_q;

    scan_t      lk;
    logic       accept;
    logic       frame_start;
    logic [7:0] frame_byte;
    logic       frame_busy;
    logic       frame_done;

    assign lk     = scan_lookup(cmd_kind_i, cmd_value_i);
    assign accept = cmd_valid_i && (state_q == StIdle);

    // Frames start on the same edge the FSM moves, so the first start bit
    // appears the cycle after acceptance.
    always_comb begin
        frame_start = 1'b0;
        frame_byte  = code_q;
        unique case (state_q)
            StIdle: begin
                if (accept && lk.valid && !(AutoBreak && cmd_release_i)) begin
                    frame_start = 1'b1;
                    frame_byte  = cmd_release_i ? K_BREAK : lk.code;
                end
            end
            StGap1: begin
                if (gap_q == GapLast) begin
                    frame_start = 1'b1;
                end
            end
            StGap2: begin
                if ((gap_q == GapLast) && brk_pending_q) begin
                    frame_start = 1'b1;
                    frame_byte  = K_BREAK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            code_q        <= 8'h00;
            cur_byte_q    <= 8'h00;
            err_q         <= 1'b0;
            gap_q         <= '0;
            brk_pending_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (frame_start) begin
                cur_byte_q <= frame_byte;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        code_q <= lk.code;
                        gap_q  <= '0;
                        if (AutoBreak && cmd_release_i) begin
                            state_q <= StIdle;
                        end else if (!lk.valid) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else if (cmd_release_i) begin
                            state_q <= StPrefix;
                        end else begin
                            state_q       <= StCode;
                            brk_pending_q <= AutoBreak;
                        end
                    end
                end
                StPrefix: begin
                    if (frame_done) begin
                        state_q <= StGap1;
                        gap_q   <= '0;
                    end
                end
                StGap1: begin
                    if (gap_q == GapLast) begin
                        state_q <= StCode;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                StCode: begin
                    if (frame_done) begin
                        state_q <= StGap2;
                        gap_q   <= '0;
                    end
                end
                StGap2: begin
                    if (gap_q == GapLast) begin
                        if (brk_pending_q) begin
                            state_q       <= StPrefix;
                            brk_pending_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    ps2_frame_tx #(
        .HALF_BIT(HALF_BIT)
    ) u_frame (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (frame_start),
        .byte_i   (frame_byte),
        .busy_o   (frame_busy),
        .done_o   (frame_done),
        .ps2_clk_o(ps2_clk_o),
        .ps2_dat_o(ps2_dat_o)
    );

    // busy is implied by the FSM state; kept on the port for other users
    logic unused_busy;
    assign unused_busy = frame_busy;

    assign cmd_ready_o = (state_q == StIdle);
    assign byte_done_o = frame_done;
    assign cur_byte_o  = cur_byte_q;
    assign cmd_err_o   = err_q;

endmodule

// File: doc/ps2_scancode_tx.md
Name: ps2_scancode_tx

Overview:
- Transmit side of the keyboard front end: turns note, octave, playback and load commands back into PS/2 Set-2 scan-code frames.
- Frames carry make codes, and break codes with the F0 prefix.
- Used to replay recorded sessions and as the stimulus source that drives the keyboard-decoding path over real PS/2 clock/data lines.
- Byte-level valid/ready command input; bit-level PS/2 device-side serial output.

Parameters:
- HALF_BIT, 2500: clk cycles per PS/2 clock half-period (50 MHz -> 10 kHz bit clock); must be >=2.
- GAP_CYCLES, 5000: idle cycles (both lines high) between consecutive bytes and after each command.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- cmd_valid in 1: command offered.
- cmd_ready out 1: block can accept a command.
- cmd_kind in 2: 0=NOTE, 1=OCTAVE, 2=PLAYBACK, 3=LOAD.
- cmd_value in 4: note 1..12 (A..G#) for NOTE; octave 0..3 in bits [1:0] for OCTAVE; ignored otherwise.
- cmd_release in 1: 0=key press (make), 1=key release (F0 + code).
- ps2_clk out 1: PS/2 clock, idle high.
- ps2_dat out 1: PS/2 data, idle high.
- byte_done out 1: one-cycle pulse when a frame's stop bit completes.
- cur_byte out 8: byte currently or last transmitted.
- cmd_err out 1: one-cycle pulse when a command is rejected.

Behaviour:
- Reset values: ps2_clk=1, ps2_dat=1, cmd_ready=1, byte_done=0, cur_byte=0, cmd_err=0, FSM=IDLE. Reset mid-frame aborts immediately; the next cycle shows the reset values.
- Accept rule: a command is accepted on a cycle with cmd_valid & cmd_ready. cmd_ready=1 only in IDLE. kind, value and release are latched at acceptance; later input changes are ignored.
- Code map, NOTE 1..12: 1C, 15, 1B, 23, 24, 2B, 2D, 34, 33, 35, 3B, 3C.
- Code map, OCTAVE 0..3: 16, 1E, 26, 25. PLAYBACK: 5A. LOAD: 29.
- Invalid command (NOTE with value 0 or 13..15):
  - Accepted, nothing emitted.
  - cmd_err pulses the cycle after acceptance.
  - cmd_ready returns high on the following cycle.
- States: IDLE -> PREFIX (release only) -> GAP1 -> CODE -> GAP2 -> IDLE. A press skips PREFIX and GAP1.
- Frame format: 11 bits, LSB first: start 0, d0..d7, odd parity (parity bit makes the count of ones in d0..d7 plus parity odd), stop 1.
- Per bit: ps2_dat updates on the first cycle of the high phase. ps2_clk is high for HALF_BIT cycles, then low for HALF_BIT cycles. The receiver samples on the falling edge.
- Frame length is exactly 22*HALF_BIT cycles.
- The first frame's start bit is driven the cycle after acceptance.
- After each stop-bit low phase, ps2_clk and ps2_dat return high.
- Gaps: GAP_CYCLES idle cycles follow each byte, including the last byte before IDLE.
- byte_done: pulses on the last low-phase cycle of the stop bit.
- cur_byte: loads at the start of each frame (F0 for the prefix frame).
- Counters: half-bit counter ceil(log2(HALF_BIT)) bits and bit index 4 bits, both wrap to 0 at each frame start. Gap counter ceil(log2(GAP_CYCLES+1)) bits.

Optional Feature:
- Macro: PS2_AUTO_BREAK_EN.
- Defined: a press command with cmd_release=0 transmits code, GAP, F0, GAP, code, GAP as one command; cmd_ready stays low throughout. A release command is accepted and silently dropped (no frames, no cmd_err).
- Undefined: behaviour exactly as specified above.

Decomposition:
- Package music_kbd_pkg:
  - scan-code localparams (K_A..K_GS, K_1..K_4, K_SPACE, K_ENTER, K_BREAK=8'hF0);
  - cmd_kind encoding constants;
  - function mapping kind/value to code plus a valid flag.
- Sub-module ps2_frame_tx: one-byte serializer with HALF_BIT parameter, start/busy/done handshake and clk/dat outputs. The top-level FSM sequences bytes and gaps.

Test Plan (HALF_BIT=4, GAP_CYCLES=8):
- Reset held 3 cycles mid-frame -> next cycle ps2_clk=1, ps2_dat=1, cmd_ready=1; no byte_done afterward.
- NOTE value 1 press -> one frame, 88 cycles; data bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1; byte_done once; cmd_ready high 8 cycles after the stop bit.
- OCTAVE value 2 release -> frame F0 (parity 1), 8 idle cycles, frame 26 (parity 0); cur_byte=F0 then 26; two byte_done pulses.
- NOTE value 13 -> cmd_err pulse the cycle after acceptance; ps2 lines stay high; cmd_ready=1 two cycles after acceptance.
- cmd_valid held with a second command during transmission -> ignored until IDLE; then accepted exactly once; the first command's bytes are unaffected.
- PS2_AUTO_BREAK_EN defined, LOAD press -> frames 29, F0, 29 each separated by 8 idle cycles; a LOAD release command produces no activity.
